// File: rtl/prf_multiport_pkg.sv
// Shared defaults and tag/writeback types for the multiported physical register file.
package prf_multiport_pkg;

  localparam int PHY_REGS_DEF   = 64;
  localparam int PHY_WIDTH_DEF  = $clog2(PHY_REGS_DEF);
  localparam int DATA_WIDTH_DEF = 32;

  typedef logic [PHY_WIDTH_DEF-1:0] phys_tag_t;

  typedef struct packed {
    logic                      valid;
    phys_tag_t                 tag;
    logic [DATA_WIDTH_DEF-1:0] data;
  } prf_wb_t;

endpackage

// File: rtl/prf_read_port.sv
// One PRF read port: writeback bypass over all writeback ports, tag-0/disable forcing,
// and an optional output register selected by READ_LAT.
module prf_read_port
  import prf_multiport_pkg::*;
#(
  parameter int PHY_WIDTH  = PHY_WIDTH_DEF,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int NUM_WB     = 3,
  parameter int READ_LAT   = 0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush,
  input  logic                         rd_en,
  input  logic [PHY_WIDTH-1:0]         rd_tag,
  input  logic [DATA_WIDTH-1:0]        arr_data,
  input  logic [NUM_WB-1:0]            wb_valid,
  input  logic [NUM_WB*PHY_WIDTH-1:0]  wb_tag,
  input  logic [NUM_WB*DATA_WIDTH-1:0] wb_data,
  output logic [DATA_WIDTH-1:0]        rd_data
);

  logic [DATA_WIDTH-1:0] byp_data;
  logic [DATA_WIDTH-1:0] rd_q;

  // Later writeback ports override earlier ones, matching the array write priority.
  always_comb begin
    byp_data = arr_data;
    for (int j = 0; j < NUM_WB; j++) begin
      byp_data = (wb_valid[j] && (wb_tag[j*PHY_WIDTH +: PHY_WIDTH] == rd_tag))
                 ? wb_data[j*DATA_WIDTH +: DATA_WIDTH] : byp_data;
    end
    byp_data = (!rd_en || (rd_tag == {PHY_WIDTH{1'b0}})) ? {DATA_WIDTH{1'b0}} : byp_data;
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      rd_q <= {DATA_WIDTH{1'b0}};
    end else begin
      rd_q <= byp_data;
    end
  end

  assign rd_data = (READ_LAT != 0) ? rd_q : byp_data;

endmodule

// File: rtl/prf_multiport.sv
// Physical register file with ready scoreboard, wakeup broadcast and writeback conflict flag.
module prf_multiport
  import prf_multiport_pkg::*;
#(
  parameter int PHY_REGS   = PHY_REGS_DEF,
  parameter int PHY_WIDTH  = $clog2(PHY_REGS),
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int NUM_RD     = 6,
  parameter int NUM_WB     = 3,
  parameter int NUM_ALLOC  = 2,
  parameter int READ_LAT   = 0
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           flush,
  input  logic [NUM_ALLOC-1:0]           alloc_valid,
  input  logic [NUM_ALLOC*PHY_WIDTH-1:0] alloc_tag,
  input  logic [NUM_RD-1:0]              rd_en,
  input  logic [NUM_RD*PHY_WIDTH-1:0]    rd_tag,
  output logic [NUM_RD*DATA_WIDTH-1:0]   rd_data,
  input  logic [NUM_WB-1:0]              wb_valid,
  input  logic [NUM_WB*PHY_WIDTH-1:0]    wb_tag,
  input  logic [NUM_WB*DATA_WIDTH-1:0]   wb_data,
  output logic [PHY_REGS-1:0]            ready,
  output logic [NUM_WB-1:0]              wakeup_valid,
  output logic [NUM_WB*PHY_WIDTH-1:0]    wakeup_tag,
  output logic                           wb_conflict,
  output logic [PHY_REGS*DATA_WIDTH-1:0] prf_data_out
);

  localparam logic [PHY_WIDTH-1:0] TAG_ZERO = {PHY_WIDTH{1'b0}};

  logic [DATA_WIDTH-1:0] mem [PHY_REGS];
  logic                  conflict_s;

  always_comb begin
    conflict_s = 1'b0;
    for (int j = 0; j < NUM_WB; j++) begin
      for (int k = j + 1; k < NUM_WB; k++) begin
        conflict_s = conflict_s | (wb_valid[j] && wb_valid[k]
                     && (wb_tag[j*PHY_WIDTH +: PHY_WIDTH] == wb_tag[k*PHY_WIDTH +: PHY_WIDTH])
                     && (wb_tag[j*PHY_WIDTH +: PHY_WIDTH] != TAG_ZERO));
      end
    end
  end

  // Array write: ascending loop lets the highest-index writeback win; tag 0 is never written.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < PHY_REGS; r++) mem[r] <= {DATA_WIDTH{1'b0}};
    end else begin
      for (int j = 0; j < NUM_WB; j++) begin
        if (wb_valid[j] && (wb_tag[j*PHY_WIDTH +: PHY_WIDTH] != TAG_ZERO)) begin
          mem[wb_tag[j*PHY_WIDTH +: PHY_WIDTH]] <= wb_data[j*DATA_WIDTH +: DATA_WIDTH];
        end
      end
    end
  end

  // Scoreboard: writebacks set, allocations (issued after) clear, tag 0 pinned ready.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      ready <= {PHY_REGS{1'b1}};
    end else begin
      for (int j = 0; j < NUM_WB; j++) begin
        if (wb_valid[j]) ready[wb_tag[j*PHY_WIDTH +: PHY_WIDTH]] <= 1'b1;
      end
      for (int k = 0; k < NUM_ALLOC; k++) begin
        if (alloc_valid[k]) ready[alloc_tag[k*PHY_WIDTH +: PHY_WIDTH]] <= 1'b0;
      end
      ready[0] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wakeup_valid <= {NUM_WB{1'b0}};
      wakeup_tag   <= {(NUM_WB*PHY_WIDTH){1'b0}};
    end else begin
      wakeup_valid <= wb_valid;
      wakeup_tag   <= wb_tag;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wb_conflict <= 1'b0;
    end else begin
      wb_conflict <= conflict_s;
    end
  end

  for (genvar r = 0; r < PHY_REGS; r++) begin : g_dbg
    assign prf_data_out[r*DATA_WIDTH +: DATA_WIDTH] = mem[r];
  end

  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
    prf_read_port #(
      .PHY_WIDTH (PHY_WIDTH),
      .DATA_WIDTH(DATA_WIDTH),
      .NUM_WB    (NUM_WB),
      .READ_LAT  (READ_LAT)
    ) u_rd (
      .clk     (clk),
      .rst     (rst),
      .flush   (flush),
      .rd_en   (rd_en[i]),
      .rd_tag  (rd_tag[i*PHY_WIDTH +: PHY_WIDTH]),
      .arr_data(mem[rd_tag[i*PHY_WIDTH +: PHY_WIDTH]]),
      .wb_valid(wb_valid),
      .wb_tag  (wb_tag),
      .wb_data (wb_data),
      .rd_data (rd_data[i*DATA_WIDTH +: DATA_WIDTH])
    );
  end

endmodule

// File: tb/tb_prf_multiport.sv
// Bench for prf_multiport: a READ_LAT=0 and a READ_LAT=1 instance share stimulus and are
// checked every cycle against a rule-level model, plus directed literal expectations.
module tb_prf_multiport;

  localparam int PR = 64, PW = 6, DW = 32, NR = 6, NW = 3, NA = 2;

  logic clk = 1'b0;
  logic rst, flush;
  logic [NA-1:0]    alloc_valid;
  logic [NA*PW-1:0] alloc_tag;
  logic [NR-1:0]    rd_en;
  logic [NR*PW-1:0] rd_tag;
  logic [NW-1:0]    wb_valid;
  logic [NW*PW-1:0] wb_tag;
  logic [NW*DW-1:0] wb_data;

  logic [NR*DW-1:0] rd_data0, rd_data1;
  logic [PR-1:0]    ready0, ready1;
  logic [NW-1:0]    wkv0, wkv1;
  logic [NW*PW-1:0] wkt0, wkt1;
  logic             conf0, conf1;
  logic [PR*DW-1:0] dbg0, dbg1;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  prf_multiport #(.READ_LAT(0)) dut0 (
    .clk(clk), .rst(rst), .flush(flush), .alloc_valid(alloc_valid), .alloc_tag(alloc_tag),
    .rd_en(rd_en), .rd_tag(rd_tag), .rd_data(rd_data0), .wb_valid(wb_valid), .wb_tag(wb_tag),
    .wb_data(wb_data), .ready(ready0), .wakeup_valid(wkv0), .wakeup_tag(wkt0),
    .wb_conflict(conf0), .prf_data_out(dbg0));

  prf_multiport #(.READ_LAT(1)) dut1 (
    .clk(clk), .rst(rst), .flush(flush), .alloc_valid(alloc_valid), .alloc_tag(alloc_tag),
    .rd_en(rd_en), .rd_tag(rd_tag), .rd_data(rd_data1), .wb_valid(wb_valid), .wb_tag(wb_tag),
    .wb_data(wb_data), .ready(ready1), .wakeup_valid(wkv1), .wakeup_tag(wkt1),
    .wb_conflict(conf1), .prf_data_out(dbg1));

  // ---------------- reference model ----------------
  bit [DW-1:0]    m_mem [PR];
  bit [PR-1:0]    m_ready;
  bit [NW-1:0]    m_wkv;
  bit [NW*PW-1:0] m_wkt;
  bit             m_conf;
  bit [DW-1:0]    m_lat1 [NR];
  bit             started = 1'b0;

  function automatic bit [DW-1:0] expect_read(int i);
    int t;
    bit [DW-1:0] v;
    if (!rd_en[i]) return '0;
    t = int'(rd_tag[i*PW +: PW]);
    if (t == 0) return '0;
    v = m_mem[t];
    for (int j = 0; j < NW; j++)
      if (wb_valid[j] && int'(wb_tag[j*PW +: PW]) == t) v = wb_data[j*DW +: DW];
    return v;
  endfunction

  function automatic bit conflict_now();
    for (int j = 0; j < NW; j++)
      for (int k = j + 1; k < NW; k++)
        if (wb_valid[j] && wb_valid[k] && wb_tag[j*PW +: PW] == wb_tag[k*PW +: PW]
            && wb_tag[j*PW +: PW] != 6'd0) return 1'b1;
    return 1'b0;
  endfunction

  always @(posedge clk) begin
    for (int i = 0; i < NR; i++) m_lat1[i] <= (rst || flush) ? 32'd0 : expect_read(i);
    if (rst) begin
      for (int r = 0; r < PR; r++) m_mem[r] <= 32'd0;
      m_ready <= '1;
      m_wkv   <= '0;
      m_wkt   <= '0;
      m_conf  <= 1'b0;
      started <= 1'b1;
    end else begin
      for (int j = 0; j < NW; j++)
        if (wb_valid[j] && wb_tag[j*PW +: PW] != 6'd0) m_mem[wb_tag[j*PW +: PW]] <= wb_data[j*DW +: DW];
      m_conf <= conflict_now();
      if (flush) begin
        m_ready <= '1;
        m_wkv   <= '0;
        m_wkt   <= '0;
      end else begin
        for (int j = 0; j < NW; j++) if (wb_valid[j]) m_ready[wb_tag[j*PW +: PW]] <= 1'b1;
        for (int k = 0; k < NA; k++) if (alloc_valid[k]) m_ready[alloc_tag[k*PW +: PW]] <= 1'b0;
        m_ready[0] <= 1'b1;
        m_wkv <= wb_valid;
        m_wkt <= wb_tag;
      end
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (started) begin
      check("ready0", ready0, m_ready);
      check("ready1", ready1, m_ready);
      check("wakeup_valid", {wkv1, wkv0}, {m_wkv, m_wkv});
      check("wakeup_tag", {wkt1, wkt0}, {m_wkt, m_wkt});
      check("wb_conflict", {conf1, conf0}, {m_conf, m_conf});
      for (int i = 0; i < NR; i++) begin
        check($sformatf("rd_lat0[%0d]", i), rd_data0[i*DW +: DW], expect_read(i));
        check($sformatf("rd_lat1[%0d]", i), rd_data1[i*DW +: DW], m_lat1[i]);
      end
      for (int r = 0; r < PR; r++)
        check($sformatf("array[%0d]", r), {dbg1[r*DW +: DW], dbg0[r*DW +: DW]}, {m_mem[r], m_mem[r]});
    end
  end

  // ---------------- stimulus ----------------
  task automatic clear_inputs();
    flush = 1'b0; alloc_valid = '0; alloc_tag = '0; rd_en = '0; rd_tag = '0;
    wb_valid = '0; wb_tag = '0; wb_data = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_wb(input int j, input int tag, input logic [DW-1:0] d);
    wb_valid[j] = 1'b1; wb_tag[j*PW +: PW] = PW'(tag); wb_data[j*DW +: DW] = d;
  endtask

  task automatic set_alloc(input int k, input int tag);
    alloc_valid[k] = 1'b1; alloc_tag[k*PW +: PW] = PW'(tag);
  endtask

  task automatic set_rd(input int i, input int tag);
    rd_en[i] = 1'b1; rd_tag[i*PW +: PW] = PW'(tag);
  endtask

  initial begin
    clear_inputs();
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;

    // All tags read back zero after reset.
    for (int base = 0; base < PR; base += NR) begin
      for (int i = 0; i < NR; i++) set_rd(i, (base + i) % PR);
      tick();
    end
    check("lit_reset_ready", ready0, 64'hFFFF_FFFF_FFFF_FFFF);
    check("lit_reset_conflict", conf0, 1'b0);
    clear_inputs();

    // Alloc 5, then writeback 5 with a same-cycle read.
    set_alloc(0, 5); tick();
    check("lit_alloc5_ready", ready0[5], 1'b0);
    clear_inputs();
    set_wb(0, 5, 32'hDEAD_BEEF); set_rd(0, 5); #1;
    check("lit_bypass_lat0", rd_data0[31:0], 32'hDEAD_BEEF);
    tick();
    check("lit_bypass_lat1", rd_data1[31:0], 32'hDEAD_BEEF);
    check("lit_wb5_ready", ready0[5], 1'b1);
    check("lit_wakeup", wkv0, 3'b001);
    clear_inputs();

    // Two writebacks to tag 9.
    set_wb(0, 9, 32'h11); set_wb(2, 9, 32'h22); tick();
    check("lit_conflict_on", conf0, 1'b1);
    check("lit_array9", dbg0[9*DW +: DW], 32'h22);
    clear_inputs(); tick();
    check("lit_conflict_off", conf0, 1'b0);

    // Alloc and writeback to tag 12 together.
    set_alloc(1, 12); set_wb(1, 12, 32'h0000_ABCD); tick();
    check("lit_ready12", ready0[12], 1'b0);
    check("lit_array12", dbg0[12*DW +: DW], 32'h0000_ABCD);
    clear_inputs();

    // Tag 0 is hardwired.
    set_wb(0, 0, 32'hFFFF_FFFF); set_alloc(0, 0); set_rd(0, 0); #1;
    check("lit_tag0_lat0", rd_data0[31:0], 32'd0);
    tick();
    check("lit_tag0_ready", ready0[0], 1'b1);
    check("lit_tag0_lat1", rd_data1[31:0], 32'd0);
    check("lit_tag0_array", dbg0[31:0], 32'd0);
    clear_inputs();

    // Alloc 3/4, then flush with a simultaneous alloc of 7.
    set_alloc(0, 3); set_alloc(1, 4); set_rd(0, 9); tick();
    check("lit_ready3", ready0[3], 1'b0);
    check("lit_pre_flush_lat1", rd_data1[31:0], 32'h22);
    flush = 1'b1; alloc_valid = '0; set_alloc(0, 7); tick();
    check("lit_flush_ready", ready0, 64'hFFFF_FFFF_FFFF_FFFF);
    check("lit_flush_lat1", rd_data1[31:0], 32'd0);
    flush = 1'b0; alloc_valid = '0;
    tick();
    check("lit_post_flush_lat1", rd_data1[31:0], 32'h22);
    rst = 1'b1; tick();
    check("lit_rst_lat1", rd_data1[31:0], 32'd0);
    check("lit_rst_array9", dbg0[9*DW +: DW], 32'd0);
    rst = 1'b0;
    clear_inputs();

    // Mixed traffic on a small tag range to hit bypass, conflicts and alloc/wb overlap.
    for (int c = 0; c < 80; c++) begin
      clear_inputs();
      for (int j = 0; j < NW; j++)
        if ($urandom_range(0, 3) != 0) set_wb(j, $urandom_range(0, 11), $urandom);
      for (int k = 0; k < NA; k++)
        if ($urandom_range(0, 2) == 0) set_alloc(k, $urandom_range(0, 11));
      for (int i = 0; i < NR; i++)
        if ($urandom_range(0, 4) != 0) set_rd(i, $urandom_range(0, 11));
      flush = (c % 17 == 16);
      rst   = (c == 50);
      tick();
    end
    rst = 1'b0;
    clear_inputs();
    tick();
    @(negedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
